// File: rtl/uart_echo_buffer.sv
// UART echo buffer: a FIFO sits between a uart_rx strobe interface and a
// uart_tx start/busy interface. In echo mode the FIFO is drained to the
// transmitter one byte at a time; in hold mode bytes are only buffered.
// Alongside the FIFO the block keeps the most recent byte, a wrapping
// received-byte counter for a hex display, and a sticky overflow flag.
module uart_echo_buffer #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int NUM_DIGITS = 3
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_rx_rdy,
   input  logic [DATA_W-1:0]         i_rx_data,
   input  logic                      i_mode,
   input  logic                      i_tx_busy,
   output logic                      o_tx_start,
   output logic [DATA_W-1:0]         o_tx_data,
   output logic [DATA_W-1:0]         o_last,
   output logic [4*NUM_DIGITS-1:0]   o_count,
   output logic [$clog2(DEPTH):0]    o_level,
   output logic                      o_overflow
);

   // Pointer width indexes the storage; the level needs one extra bit so
   // that a completely full FIFO (level == DEPTH) is representable.
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = 4 * NUM_DIGITS;

   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

   // Transmit sequencing. GUARD exists because uart_tx raises busy one
   // cycle after it sees the start strobe, so busy is not trusted there.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      GUARD = 2'd2,
      WAIT  = 2'd3
   } txState_e;

   txState_e            state_q;
   logic                txStart_q;
   logic [DATA_W-1:0]   txData_q;

   // FIFO storage and bookkeeping. DEPTH is a power of two, so the
   // pointers simply wrap at their natural width.
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wrPtr_q, wrPtr_d;
   logic [AW-1:0]       rdPtr_q, rdPtr_d;
   logic [LW-1:0]       level_q, level_d;

   // Display-side state.
   logic [CW-1:0]       count_q, count_d;
   logic [DATA_W-1:0]   last_q, last_d;
   logic                overflow_q, overflow_d;

   // Per-cycle FIFO events.
   logic                fifoFull;
   logic                fifoEmpty;
   logic                popEn;
   logic                pushEn;
   logic                dropEn;

   // Decide this cycle's push/pop/drop. The pop is tied to the START state,
   // which only ever follows a non-empty FIFO, so a pop always has data.
   // A push into a full FIFO is still accepted when the pop frees a slot
   // in the same cycle.
   always_comb begin
      fifoFull  = (level_q == LEVEL_FULL);
      fifoEmpty = (level_q == '0);
      popEn     = (state_q == START);
      pushEn    = i_rx_rdy && (!fifoFull || popEn);
      dropEn    = i_rx_rdy && fifoFull && !popEn;
   end

   // Next-state values for pointers, occupancy and the display registers.
   // The last byte and the counter follow every strobe, even a dropped one.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      level_d    = level_q;
      count_d    = count_q;
      last_d     = last_q;
      overflow_d = overflow_q;

      if (pushEn) begin
         wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (popEn) begin
         rdPtr_d = rdPtr_q + PTR_ONE;
      end

      case ({pushEn, popEn})
         2'b10:   level_d = level_q + LEVEL_ONE;
         2'b01:   level_d = level_q - LEVEL_ONE;
         default: level_d = level_q;
      endcase

      if (i_rx_rdy) begin
         count_d = count_q + COUNT_ONE;
         last_d  = i_rx_data;
      end

      if (dropEn) begin
         overflow_d = 1'b1;
      end
   end

   // Register the FIFO bookkeeping and display state; reset wins over a
   // strobe arriving in the same cycle, so that byte is neither kept nor
   // counted.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         level_q    <= '0;
         count_q    <= '0;
         last_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         level_q    <= level_d;
         count_q    <= count_d;
         last_q     <= last_d;
         overflow_q <= overflow_d;
      end
   end

   // Write accepted bytes into storage. The array itself carries no reset;
   // emptiness is defined purely by the pointers and level.
   always_ff @(posedge i_clk) begin
      if (pushEn && !i_reset) begin
         mem[wrPtr_q] <= i_rx_data;
      end
   end

   // Transmit FSM with registered start/data outputs. The head byte is
   // captured on the way into START so it is presented during the START
   // cycle, the same cycle the FIFO pops it. Mode is only consulted in
   // IDLE, so a byte already launched is always carried to completion,
   // and reset simply abandons whatever was in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= IDLE;
         txStart_q <= 1'b0;
         txData_q  <= '0;
      end else begin
         txStart_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!i_mode && !fifoEmpty && !i_tx_busy) begin
                  state_q   <= START;
                  txStart_q <= 1'b1;
                  txData_q  <= mem[rdPtr_q];
               end
            end
            START: begin
               state_q <= GUARD;
            end
            GUARD: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (!i_tx_busy) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Drive the outputs straight from their registers.
   always_comb begin
      o_tx_start = txStart_q;
      o_tx_data  = txData_q;
      o_last     = last_q;
      o_count    = count_q;
      o_level    = level_q;
      o_overflow = overflow_q;
   end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer: a queue-based behavioural model
// predicts every output each cycle, and directed scenarios pin the model
// with hand-computed literal expectations.
module tb_uart_echo_buffer;

   localparam int DATA_W     = 8;
   localparam int DEPTH      = 16;
   localparam int NUM_DIGITS = 3;
   localparam int LW         = $clog2(DEPTH) + 1;
   localparam int CW         = 4 * NUM_DIGITS;

   logic                clock = 1'b0;
   logic                reset;
   logic                rxRdy;
   logic [DATA_W-1:0]   rxData;
   logic                mode;
   logic                txBusy;
   logic                txStart;
   logic [DATA_W-1:0]   txData;
   logic [DATA_W-1:0]   lastByte;
   logic [CW-1:0]       count;
   logic [LW-1:0]       level;
   logic                overflow;

   int checks = 0;
   int errors = 0;

   // Clock generation
   always #5 clock = ~clock;

   uart_echo_buffer #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .NUM_DIGITS (NUM_DIGITS)
   ) dut (
      .i_clk      (clock),
      .i_reset    (reset),
      .i_rx_rdy   (rxRdy),
      .i_rx_data  (rxData),
      .i_mode     (mode),
      .i_tx_busy  (txBusy),
      .o_tx_start (txStart),
      .o_tx_data  (txData),
      .o_last     (lastByte),
      .o_count    (count),
      .o_level    (level),
      .o_overflow (overflow)
   );

   // Single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model state: a byte queue plus timestamps of transmit events
   logic [DATA_W-1:0]   mq[$];
   logic                modelValid = 1'b0;
   logic                eStart;
   logic [DATA_W-1:0]   eData;
   int                  eLevel;
   logic [CW-1:0]       eCount;
   logic [DATA_W-1:0]   eLast;
   logic                eOvf;
   longint              mCyc = 0;
   longint              lastStart;
   bit                  sawLow;
   bit                  mIdle;
   bit                  mNextStart;
   logic [DATA_W-1:0]   mHead;

   // Model update on each active edge from the inputs seen at that edge.
   // The sender is free once, at least two cycles after a start, a cycle
   // with busy low has gone by; a start comes one cycle after the sender
   // is free, echo mode is selected, bytes are waiting and busy is low.
   always @(posedge clock) begin
      if (reset) begin
         mq.delete();
         eStart     = 1'b0;
         eData      = '0;
         eLevel     = 0;
         eCount     = '0;
         eLast      = '0;
         eOvf       = 1'b0;
         lastStart  = -1;
         sawLow     = 1'b0;
         modelValid = 1'b1;
      end else begin
         mIdle = !eStart && (lastStart < 0 || sawLow);
         if (eStart) begin
            lastStart = mCyc;
            sawLow    = 1'b0;
         end
         if (lastStart >= 0 && mCyc >= lastStart + 2 && !txBusy) sawLow = 1'b1;
         mNextStart = mIdle && !mode && (mq.size() > 0) && !txBusy;
         mHead      = (mq.size() > 0) ? mq[0] : '0;
         if (eStart) void'(mq.pop_front());
         if (rxRdy) begin
            eLast  = rxData;
            eCount = eCount + 12'd1;
            if (mq.size() < DEPTH) mq.push_back(rxData);
            else eOvf = 1'b1;
         end
         eLevel = mq.size();
         if (mNextStart) eData = mHead;
         eStart = mNextStart;
      end
      mCyc++;
   end

   // Transmitted-byte log for the directed scenarios
   logic [DATA_W-1:0]   txLog[$];
   longint              startCyc[$];

   // Compare every output against the model once per cycle, mid-cycle
   always @(negedge clock) begin
      if (modelValid) begin
         checkOutput("tx_start", 32'(txStart), 32'(eStart));
         checkOutput("tx_data",  32'(txData),  32'(eData));
         checkOutput("level",    32'(level),   32'(eLevel));
         checkOutput("count",    32'(count),   32'(eCount));
         checkOutput("last",     32'(lastByte), 32'(eLast));
         checkOutput("overflow", 32'(overflow), 32'(eOvf));
         if (txStart) begin
            txLog.push_back(txData);
            startCyc.push_back(mCyc);
         end
      end
   end

   // Stand-in for uart_tx: busy for busyLen cycles after each start
   int busyLen  = 0;
   int busyLeft = 0;
   always @(negedge clock) begin
      if (txStart) busyLeft = busyLen;
      else if (busyLeft > 0) busyLeft--;
      txBusy = (busyLeft > 0);
   end

   // One strobe with a single idle cycle after it
   task automatic applyStimulus(input logic [DATA_W-1:0] d);
      @(negedge clock);
      rxRdy  = 1'b1;
      rxData = d;
      @(negedge clock);
      rxRdy  = 1'b0;
   endtask

   // One-cycle reset pulse, then check every output is cleared
   task automatic doReset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      rxRdy = 1'b0;
      checkOutput("rst_tx_start", 32'(txStart), 32'h0);
      checkOutput("rst_tx_data",  32'(txData),  32'h0);
      checkOutput("rst_level",    32'(level),   32'h0);
      checkOutput("rst_count",    32'(count),   32'h0);
      checkOutput("rst_last",     32'(lastByte), 32'h0);
      checkOutput("rst_overflow", 32'(overflow), 32'h0);
   endtask

   // Bounded wait for n logged transmissions
   task automatic waitTx(input int n, input int budget);
      int k = 0;
      while (txLog.size() < n && k < budget) begin
         @(negedge clock);
         k++;
      end
      checkOutput("tx_timeout", 32'(txLog.size() >= n), 32'h1);
   endtask

   longint rdyCyc;

   initial begin
      reset  = 1'b1;
      rxRdy  = 1'b0;
      rxData = '0;
      mode   = 1'b1;
      txBusy = 1'b0;
      repeat (2) @(negedge clock);
      doReset();

      // Reset takes priority over a simultaneous strobe
      @(negedge clock);
      reset  = 1'b1;
      rxRdy  = 1'b1;
      rxData = 8'h55;
      @(negedge clock);
      reset  = 1'b0;
      rxRdy  = 1'b0;
      checkOutput("rst_rdy_count", 32'(count), 32'h0);
      checkOutput("rst_rdy_level", 32'(level), 32'h0);
      checkOutput("rst_rdy_last",  32'(lastByte), 32'h0);

      // Echo: single byte, two-cycle latency to the start strobe
      $display("[TB] echo");
      mode    = 1'b0;
      busyLen = 10;
      txLog.delete();
      startCyc.delete();
      @(negedge clock);
      rxRdy  = 1'b1;
      rxData = 8'h3A;
      rdyCyc = mCyc;
      @(negedge clock);
      rxRdy  = 1'b0;
      waitTx(1, 20);
      checkOutput("echo_data",    32'(txLog[0]), 32'h3A);
      checkOutput("echo_latency", 32'(startCyc[0] - rdyCyc), 32'd2);
      repeat (15) @(negedge clock);
      checkOutput("echo_last",  32'(lastByte), 32'h3A);
      checkOutput("echo_count", 32'(count), 32'h001);
      checkOutput("echo_level", 32'(level), 32'h0);

      // Order: buffer five bytes, then drain; one start per busy window
      $display("[TB] order");
      mode    = 1'b1;
      busyLen = 4;
      txLog.delete();
      startCyc.delete();
      for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
      repeat (3) @(negedge clock);
      checkOutput("order_hold_none", 32'(txLog.size()), 32'd0);
      mode = 1'b0;
      waitTx(5, 200);
      for (int i = 0; i < 5; i++) checkOutput("order_byte", 32'(txLog[i]), 32'(i + 1));
      for (int i = 0; i < 4; i++)
         checkOutput("order_spacing", 32'(startCyc[i+1] - startCyc[i]), 32'd6);

      // Overflow: seventeen back-to-back bytes into a sixteen-entry FIFO
      $display("[TB] overflow");
      doReset();
      mode    = 1'b1;
      busyLen = 2;
      txLog.delete();
      for (int i = 0; i < 17; i++) begin
         @(negedge clock);
         rxRdy  = 1'b1;
         rxData = 8'(16 + i);
      end
      @(negedge clock);
      rxRdy = 1'b0;
      checkOutput("ovf_level", 32'(level), 32'd16);
      checkOutput("ovf_flag",  32'(overflow), 32'h1);
      checkOutput("ovf_count", 32'(count), 32'h011);
      checkOutput("ovf_last",  32'(lastByte), 32'h20);
      mode = 1'b0;
      waitTx(16, 400);
      repeat (20) @(negedge clock);
      checkOutput("ovf_tx_count", 32'(txLog.size()), 32'd16);
      checkOutput("ovf_tx_final", 32'(txLog[15]), 32'h1F);
      checkOutput("ovf_sticky",   32'(overflow), 32'h1);

      // Full FIFO with a push landing on the START pop
      $display("[TB] full with pop");
      doReset();
      mode    = 1'b1;
      busyLen = 3;
      txLog.delete();
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         rxRdy  = 1'b1;
         rxData = 8'(64 + i);
      end
      @(negedge clock);
      rxRdy = 1'b0;
      mode  = 1'b0;
      @(negedge clock);
      rxRdy  = 1'b1;
      rxData = 8'hAA;
      checkOutput("fp_start_now", 32'(txStart), 32'h1);
      @(negedge clock);
      rxRdy = 1'b0;
      mode  = 1'b1;
      checkOutput("fp_level", 32'(level), 32'd16);
      checkOutput("fp_ovf",   32'(overflow), 32'h0);
      repeat (20) @(negedge clock);
      checkOutput("fp_hold_level", 32'(level), 32'd16);
      mode = 1'b0;
      waitTx(17, 600);
      checkOutput("fp_first", 32'(txLog[0]), 32'h40);
      checkOutput("fp_final", 32'(txLog[16]), 32'hAA);

      // Counter wrap after 4095 strobes
      $display("[TB] counter wrap");
      doReset();
      mode = 1'b1;
      for (int i = 0; i < 4095; i++) begin
         @(negedge clock);
         rxRdy  = 1'b1;
         rxData = 8'(i);
      end
      @(negedge clock);
      rxRdy = 1'b0;
      checkOutput("wrap_pre", 32'(count), 32'hFFF);
      applyStimulus(8'hC3);
      checkOutput("wrap_post", 32'(count), 32'h000);

      // Reset in WAIT with three bytes still queued
      $display("[TB] reset mid-op");
      doReset();
      mode    = 1'b1;
      busyLen = 20;
      for (int i = 0; i < 4; i++) applyStimulus(8'(97 + i));
      txLog.delete();
      mode = 1'b0;
      waitTx(1, 50);
      repeat (5) @(negedge clock);
      checkOutput("mid_level", 32'(level), 32'd3);
      doReset();
      repeat (30) @(negedge clock);
      checkOutput("mid_no_resend", 32'(txLog.size()), 32'd1);
      applyStimulus(8'h77);
      waitTx(2, 60);
      checkOutput("mid_new_byte", 32'(txLog[1]), 32'h77);

      repeat (5) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
